// File: rtl/snake_game_sequencer_pkg.sv
// Shared encodings for the snake game sequencer: game phases and travel directions.
package snake_game_sequencer_pkg;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_PLAY = 2'd1,
    MS_WIN  = 2'd2,
    MS_LOSE = 2'd3
  } masterState_t;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_UP    = 2'b10,
    DIR_LEFT  = 2'b11
  } navDir_t;

  // The encodings pair opposite directions as bitwise complements.
  function automatic logic isOpposite(input navDir_t a, input navDir_t b);
    return (a ^ b) == 2'b11;
  endfunction

endpackage

// File: rtl/snake_game_sequencer_if.sv
// Buttons and datapath status into the sequencer; game control and score out of it.
interface snake_game_sequencer_if;
  logic       BTN_START;
  logic       BTN_U;
  logic       BTN_D;
  logic       BTN_L;
  logic       BTN_R;
  logic       REACHED_TARGET;
  logic       SELF_HIT;
  logic [1:0] MASTER_STATE;
  logic [1:0] NAVIGATION_STATE;
  logic       GAME_TICK;
  logic [3:0] SCORE;
  logic       APPLE_EATEN;

  modport master (
    input  BTN_START, BTN_U, BTN_D, BTN_L, BTN_R, REACHED_TARGET, SELF_HIT,
    output MASTER_STATE, NAVIGATION_STATE, GAME_TICK, SCORE, APPLE_EATEN
  );

  modport slave (
    output BTN_START, BTN_U, BTN_D, BTN_L, BTN_R, REACHED_TARGET, SELF_HIT,
    input  MASTER_STATE, NAVIGATION_STATE, GAME_TICK, SCORE, APPLE_EATEN
  );
endinterface

// File: rtl/snake_tick_gen.sv
// Game tick divider: registered one-cycle pulse every TICK_DIV enabled cycles.
module snake_tick_gen #(
  parameter int unsigned TICK_DIV = 5000000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic enable,
  input  logic clear,
  output logic GAME_TICK
);

  localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] tickCnt;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tickCnt   <= '0;
      GAME_TICK <= 1'b0;
    end else begin
      GAME_TICK <= 1'b0;
      if (clear) begin
        tickCnt <= '0;
      end else if (enable) begin
        if (tickCnt == LAST) begin
          tickCnt   <= '0;
          GAME_TICK <= 1'b1;
        end else begin
          tickCnt <= tickCnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/snake_game_sequencer.sv
// Snake game control: phase FSM, buffered steering and apple scoring around a tick divider.
module snake_game_sequencer
  import snake_game_sequencer_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 5000000,
  parameter int unsigned WIN_SCORE = 10
) (
  input  logic                  CLK,
  input  logic                  RESET,
  snake_game_sequencer_if.master bus
);

  localparam logic [3:0] WIN_LIMIT = 4'(WIN_SCORE);

  masterState_t state, nextState;
  navDir_t      navState, pendDir, pulseDir;
  logic         pulseValid, startGame, stayPlay, gameTick;
  logic         reachedPrev, targetRise, appleEaten;
  logic [3:0]   score;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= MS_IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      MS_IDLE:         if (bus.BTN_START) nextState = MS_PLAY;
      MS_PLAY: begin
        if (bus.SELF_HIT)            nextState = MS_LOSE;
        else if (score == WIN_LIMIT) nextState = MS_WIN;
      end
      MS_WIN, MS_LOSE: if (bus.BTN_START) nextState = MS_IDLE;
      default:         nextState = MS_IDLE;
    endcase
  end

  assign startGame  = (state == MS_IDLE) && bus.BTN_START;
  // Counting stops on the cycle PLAY is left so no tick leaks into WIN/LOSE.
  assign stayPlay   = (state == MS_PLAY) && (nextState == MS_PLAY);
  assign targetRise = bus.REACHED_TARGET && !reachedPrev;

  snake_tick_gen #(.TICK_DIV(TICK_DIV)) tickGen (
    .CLK      (CLK),
    .RESET    (RESET),
    .enable   (stayPlay),
    .clear    (startGame),
    .GAME_TICK(gameTick)
  );

  always_comb begin
    pulseValid = 1'b1;
    pulseDir   = DIR_RIGHT;
    if (bus.BTN_U)      pulseDir = DIR_UP;
    else if (bus.BTN_D) pulseDir = DIR_DOWN;
    else if (bus.BTN_L) pulseDir = DIR_LEFT;
    else if (bus.BTN_R) pulseDir = DIR_RIGHT;
    else                pulseValid = 1'b0;
  end

  // The tick copies the old pending value, so a same-cycle pulse lands on the next tick.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      navState <= DIR_RIGHT;
      pendDir  <= DIR_RIGHT;
    end else if (startGame) begin
      navState <= DIR_RIGHT;
      pendDir  <= DIR_RIGHT;
    end else if (state == MS_PLAY) begin
      if (gameTick) navState <= pendDir;
      if (pulseValid && !isOpposite(pulseDir, navState)) pendDir <= pulseDir;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      reachedPrev <= 1'b0;
      score       <= '0;
      appleEaten  <= 1'b0;
    end else begin
      reachedPrev <= bus.REACHED_TARGET;
      appleEaten  <= 1'b0;
      if (startGame) begin
        score <= '0;
      end else if ((state == MS_PLAY) && targetRise && !bus.SELF_HIT &&
                   (score < WIN_LIMIT)) begin
        score      <= score + 4'd1;
        appleEaten <= 1'b1;
      end
    end
  end

  assign bus.MASTER_STATE     = state;
  assign bus.NAVIGATION_STATE = navState;
  assign bus.GAME_TICK        = gameTick;
  assign bus.SCORE            = score;
  assign bus.APPLE_EATEN      = appleEaten;

endmodule

// File: tb/tb_snake_game_sequencer.sv
// Scenario tasks plus randomized play against a rule-level game model.
module tb_snake_game_sequencer;

  localparam int unsigned TD = 4;
  localparam int unsigned WS = 3;
  localparam logic [4:0] B_NONE = 5'b00000, B_START = 5'b10000, B_U = 5'b01000,
                         B_D = 5'b00100, B_L = 5'b00010, B_R = 5'b00001;

  logic CLK = 1'b0;
  logic RESET = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 CLK = ~CLK;

  snake_game_sequencer_if bus ();

  snake_game_sequencer #(.TICK_DIV(TD), .WIN_SCORE(WS)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus.master)
  );

  // Reference model: phase 0..3, directions 0..3 (opposites sum to 3), age counts PLAY cycles.
  int mState, mNav, mPend, mScore, mAge, oldNav, oldScore, dir;
  bit mTick, mApple, mPrev, rise, hasDir, nTick, nApple;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mState = 0; mNav = 0; mPend = 0; mScore = 0; mAge = 0;
      mTick = 0; mApple = 0; mPrev = 0;
    end else begin
      rise   = bus.REACHED_TARGET && !mPrev;
      mPrev  = bus.REACHED_TARGET;
      nTick  = 0;
      nApple = 0;
      if (mState == 0) begin
        if (bus.BTN_START) begin
          mState = 1; mScore = 0; mNav = 0; mPend = 0; mAge = 0;
        end
      end else if (mState == 1) begin
        oldNav   = mNav;
        oldScore = mScore;
        if (mTick) mNav = mPend;
        hasDir = 1;
        if (bus.BTN_U)      dir = 2;
        else if (bus.BTN_D) dir = 1;
        else if (bus.BTN_L) dir = 3;
        else if (bus.BTN_R) dir = 0;
        else                hasDir = 0;
        if (hasDir && (dir + oldNav != 3)) mPend = dir;
        if (rise && !bus.SELF_HIT && mScore < int'(WS)) begin
          mScore = mScore + 1;
          nApple = 1;
        end
        if (bus.SELF_HIT) mState = 3;
        else if (oldScore == int'(WS)) mState = 2;
        else begin
          mAge  = mAge + 1;
          nTick = (mAge % TD) == 0;
        end
      end else if (bus.BTN_START) begin
        mState = 0;
      end
      mTick  = nTick;
      mApple = nApple;
    end
  end

  task automatic drive(input logic [4:0] btn, input logic rt, input logic sh);
    @(negedge CLK);
    {bus.BTN_START, bus.BTN_U, bus.BTN_D, bus.BTN_L, bus.BTN_R} = btn;
    bus.REACHED_TARGET = rt;
    bus.SELF_HIT       = sh;
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic wait_tick(output bit seen);
    seen = 0;
    for (int i = 0; i < 2 * TD && !seen; i++) begin
      drive(B_NONE, 1'b0, 1'b0);
      seen = bus.GAME_TICK;
    end
  endtask

  task automatic test_reset();
    #1 RESET = 1'b1;
    #2;
    total++; if (bus.MASTER_STATE !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", bus.MASTER_STATE); end
    total++; if (bus.NAVIGATION_STATE !== 2'd0) begin bad++; $display("FAIL reset_nav: got %0d want 0", bus.NAVIGATION_STATE); end
    total++; if (bus.SCORE !== 4'd0) begin bad++; $display("FAIL reset_score: got %0d want 0", bus.SCORE); end
    total++; if (bus.GAME_TICK !== 1'b0) begin bad++; $display("FAIL reset_tick: got %0d want 0", bus.GAME_TICK); end
    total++; if (bus.APPLE_EATEN !== 1'b0) begin bad++; $display("FAIL reset_apple: got %0d want 0", bus.APPLE_EATEN); end
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_tick();
    drive(B_START, 1'b0, 1'b0);
    total++; if (bus.MASTER_STATE !== 2'd1) begin bad++; $display("FAIL start_play: got %0d want 1", bus.MASTER_STATE); end
    for (int k = 1; k <= 12; k++) begin
      drive(B_NONE, 1'b0, 1'b0);
      total++;
      if (bus.GAME_TICK !== ((k % TD) == 0)) begin
        bad++; $display("FAIL tick_at_%0d: got %0d want %0d", k, bus.GAME_TICK, (k % TD) == 0);
      end
    end
  endtask

  task automatic test_direction();
    bit seen;
    drive(B_L, 1'b0, 1'b0);
    drive(B_D, 1'b0, 1'b0);
    wait_tick(seen);
    total++; if (!seen) begin bad++; $display("FAIL dir_tick_wait: got 0 want 1"); end
    total++; if (bus.NAVIGATION_STATE !== 2'b00) begin bad++; $display("FAIL dir_before_copy: got %0d want 0", bus.NAVIGATION_STATE); end
    drive(B_NONE, 1'b0, 1'b0);
    total++; if (bus.NAVIGATION_STATE !== 2'b01) begin bad++; $display("FAIL dir_down: got %0d want 1", bus.NAVIGATION_STATE); end
    wait_tick(seen);
    drive(B_L, 1'b0, 1'b0);
    total++; if (bus.NAVIGATION_STATE !== 2'b01) begin bad++; $display("FAIL dir_deferred: got %0d want 1", bus.NAVIGATION_STATE); end
    wait_tick(seen);
    drive(B_NONE, 1'b0, 1'b0);
    total++; if (bus.NAVIGATION_STATE !== 2'b11) begin bad++; $display("FAIL dir_left_late: got %0d want 3", bus.NAVIGATION_STATE); end
  endtask

  task automatic test_score_hold();
    int apples = 0;
    for (int i = 0; i < 10; i++) begin
      drive(B_NONE, 1'b1, 1'b0);
      apples += int'(bus.APPLE_EATEN);
    end
    drive(B_NONE, 1'b0, 1'b0);
    total++; if (apples != 1) begin bad++; $display("FAIL hold_apples: got %0d want 1", apples); end
    total++; if (bus.SCORE !== 4'd1) begin bad++; $display("FAIL hold_score: got %0d want 1", bus.SCORE); end
  endtask

  task automatic test_win();
    pulse_reset();
    drive(B_START, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(B_NONE, 1'b1, 1'b0);
      drive(B_NONE, 1'b0, 1'b0);
    end
    total++; if (bus.SCORE !== 4'd3) begin bad++; $display("FAIL win_score: got %0d want 3", bus.SCORE); end
    total++; if (bus.MASTER_STATE !== 2'd2) begin bad++; $display("FAIL win_state: got %0d want 2", bus.MASTER_STATE); end
    drive(B_NONE, 1'b1, 1'b0);
    drive(B_NONE, 1'b0, 1'b0);
    total++; if (bus.SCORE !== 4'd3) begin bad++; $display("FAIL win_saturate: got %0d want 3", bus.SCORE); end
    drive(B_START, 1'b0, 1'b0);
    total++; if (bus.MASTER_STATE !== 2'd0) begin bad++; $display("FAIL win_to_idle: got %0d want 0", bus.MASTER_STATE); end
    total++; if (bus.SCORE !== 4'd3) begin bad++; $display("FAIL win_score_kept: got %0d want 3", bus.SCORE); end
  endtask

  task automatic test_self_hit();
    drive(B_START, 1'b0, 1'b0);
    total++; if (bus.SCORE !== 4'd0) begin bad++; $display("FAIL restart_score: got %0d want 0", bus.SCORE); end
    for (int i = 0; i < 2; i++) begin
      drive(B_NONE, 1'b1, 1'b0);
      drive(B_NONE, 1'b0, 1'b0);
    end
    drive(B_NONE, 1'b1, 1'b1);
    total++; if (bus.MASTER_STATE !== 2'd3) begin bad++; $display("FAIL hit_state: got %0d want 3", bus.MASTER_STATE); end
    total++; if (bus.SCORE !== 4'd2) begin bad++; $display("FAIL hit_score: got %0d want 2", bus.SCORE); end
    total++; if (bus.APPLE_EATEN !== 1'b0) begin bad++; $display("FAIL hit_apple: got %0d want 0", bus.APPLE_EATEN); end
    drive(B_NONE, 1'b0, 1'b0);
    drive(B_START, 1'b0, 1'b0);
    total++; if (bus.MASTER_STATE !== 2'd0) begin bad++; $display("FAIL lose_to_idle: got %0d want 0", bus.MASTER_STATE); end
  endtask

  task automatic test_reset_mid();
    int ticks = 0;
    drive(B_START, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      drive(B_NONE, 1'b1, 1'b0);
      drive(B_NONE, 1'b0, 1'b0);
    end
    drive(B_R, 1'b0, 1'b0);
    drive(B_D, 1'b0, 1'b0);
    total++; if (bus.SCORE !== 4'd2) begin bad++; $display("FAIL mid_score_pre: got %0d want 2", bus.SCORE); end
    #2 RESET = 1'b1;
    #1;
    total++; if (bus.MASTER_STATE !== 2'd0) begin bad++; $display("FAIL mid_state: got %0d want 0", bus.MASTER_STATE); end
    total++; if (bus.SCORE !== 4'd0) begin bad++; $display("FAIL mid_score: got %0d want 0", bus.SCORE); end
    total++; if (bus.NAVIGATION_STATE !== 2'd0) begin bad++; $display("FAIL mid_nav: got %0d want 0", bus.NAVIGATION_STATE); end
    total++; if (bus.GAME_TICK !== 1'b0) begin bad++; $display("FAIL mid_tick: got %0d want 0", bus.GAME_TICK); end
    total++; if (bus.APPLE_EATEN !== 1'b0) begin bad++; $display("FAIL mid_apple: got %0d want 0", bus.APPLE_EATEN); end
    @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    for (int i = 0; i < 3 * TD; i++) begin
      drive(B_NONE, 1'b0, 1'b0);
      ticks += int'(bus.GAME_TICK);
    end
    total++; if (ticks != 0) begin bad++; $display("FAIL mid_no_tick: got %0d want 0", ticks); end
    total++; if (bus.MASTER_STATE !== 2'd0) begin bad++; $display("FAIL mid_stay_idle: got %0d want 0", bus.MASTER_STATE); end
  endtask

  task automatic test_random();
    logic [4:0] btn;
    logic rt = 1'b0;
    logic sh;
    for (int c = 0; c < 1500; c++) begin
      btn[4] = ($urandom_range(0, 24) == 0);
      for (int b = 0; b < 4; b++) btn[b] = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) rt = ~rt;
      sh = ($urandom_range(0, 149) == 0);
      drive(btn, rt, sh);
      total++; if (bus.MASTER_STATE !== 2'(mState)) begin bad++; $display("FAIL rnd_state c=%0d: got %0d want %0d", c, bus.MASTER_STATE, mState); end
      total++; if (bus.NAVIGATION_STATE !== 2'(mNav)) begin bad++; $display("FAIL rnd_nav c=%0d: got %0d want %0d", c, bus.NAVIGATION_STATE, mNav); end
      total++; if (bus.SCORE !== 4'(mScore)) begin bad++; $display("FAIL rnd_score c=%0d: got %0d want %0d", c, bus.SCORE, mScore); end
      total++; if (bus.GAME_TICK !== mTick) begin bad++; $display("FAIL rnd_tick c=%0d: got %0d want %0d", c, bus.GAME_TICK, mTick); end
      total++; if (bus.APPLE_EATEN !== mApple) begin bad++; $display("FAIL rnd_apple c=%0d: got %0d want %0d", c, bus.APPLE_EATEN, mApple); end
    end
  endtask

  initial begin
    {bus.BTN_START, bus.BTN_U, bus.BTN_D, bus.BTN_L, bus.BTN_R} = B_NONE;
    bus.REACHED_TARGET = 1'b0;
    bus.SELF_HIT       = 1'b0;
    test_reset();
    test_tick();
    test_direction();
    test_score_hold();
    test_win();
    test_self_hit();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
